bcd_score_accum: RTL and testbench
==================================

Name: bcd_score_accum

Overview:
- Parametrised N-digit BCD accumulator for on-screen score and level displays; successor to the fixed 2/6-digit increment-only counters.
- Adds an arbitrary multi-digit BCD addend through a ready/valid handshake, one digit per cycle, LSD first.
- Provides a leading-zero blanking mask, selectable saturate/wrap overflow handling, and a synchronous clear.
- Sits between game logic (score events) and the text/tile renderer.

Parameters:
- DIGITS, 6: number of BCD digits, 2..8.
- SATURATE, 1: 1 = clamp to all nines on overflow; 0 = wrap modulo 10^DIGITS.

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  system reset, synchronous, active high
- clear  input  1  synchronous return to zero; same effect as rst on all state
- add_valid  input  1  addend present
- add_value  input  4*DIGITS  BCD addend, digit i on bits [4i+3:4i]
- add_ready  output  1  block idle, can accept an addend
- data  output  4*DIGITS  committed BCD value
- mask  output  DIGITS  1 = digit blanked (leading zero)
- overflow  output  1  sticky: a carry out of the MSD has occurred
- done  output  1  one-cycle pulse when a sum commits

Behaviour:
- Reset (rst or clear): data=0, mask={DIGITS-1 ones, 0}, add_ready=1, done=0, overflow=0, FSM=IDLE, accumulator and carry cleared.
- rst/clear have priority over everything, including mid-operation; an in-flight add is discarded and never commits.
- FSM states:
  - IDLE: add_ready=1. Handshake add_valid&&add_ready at edge of cycle T latches add_value into the addend shadow, copies data into the work register, sets k=0, carry=0, moves to ADD.
  - ADD: add_ready=0. In cycle T+1+k, digit k = work[k] + addend[k] + carry; if the result is >9, subtract 10 and set carry. Increment k.
  - After digit DIGITS-1 (end of cycle T+DIGITS): commit, return to IDLE.
- Addend digits greater than 9 are clamped to 9 at latch time. Stored digits are always valid BCD.
- Commit at end of cycle T+DIGITS; the following are visible in cycle T+DIGITS+1:
  - data = work register.
  - Final carry=1: overflow<=1; data = all nines if SATURATE, otherwise the wrapped sum.
  - mask[i]=1 iff digit i and every digit above it are zero, for i>=1; mask[0] is always 0.
  - done=1 for exactly that cycle; add_ready=1 again.
- Latency: handshake to visible result = DIGITS+1 cycles. Maximum throughput is one add per DIGITS+1 cycles.
- add_valid while add_ready=0 is ignored. The producer holds add_valid until the handshake.
- data, mask and overflow are constant between commits; no intermediate values are ever visible.
- Adding zero still performs a full pass and pulses done; data is unchanged.
- overflow is cleared only by rst or clear.

Decomposition:
- Shared config include holds BCD constants only: BCD_NINE=4'd9, BCD_TEN=5'd10.
- One sub-module, bcd_digit_add: combinational (a[3:0], b[3:0], cin) -> (s[3:0], cout). Instantiated once and muxed by k.
- The FSM, digit index counter, work/addend registers and mask generation live in bcd_score_accum.

Test Plan:
- Reset, DIGITS=6: data=0x000000, mask=6'b111110, add_ready=1, overflow=0, done=0.
- data=000009, add 000001 -> done in cycle T+7, data=0x000010, mask=6'b111100, overflow=0.
- SATURATE=1, data=999998, add 000005 -> data=0x999999, overflow=1, mask=0. Then add 000001 -> still 0x999999, overflow=1.
- SATURATE=0, data=999998, add 000005 -> data=0x000003, overflow=1, mask=6'b111110.
- add_valid held high with 000100, then 000250 -> add_ready low for cycles T+1..T+6, second handshake at T+7, final data=0x000350. add_value changes while busy have no effect.
- Start add 123456 from 0, assert clear at cycle T+3 -> no done pulse, data=0, mask=6'b111110, add_ready=1 next cycle. Then addend digit 4'hC in digit 0 -> treated as 9, result 0x000009.

Source files
------------

// File: rtl/bcd_score_accum_pkg.sv
// BCD constants shared by the score accumulator and its digit adder.
package bcd_score_accum_pkg;
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [4:0] BCD_TEN  = 5'd10;
endpackage

// File: rtl/bcd_score_accum_digit_add.sv
// Single-digit BCD adder: s = (a + b + cin) mod 10, cout when the raw sum exceeds nine.
module bcd_digit_add
    import bcd_score_accum_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw > {1'b0, BCD_NINE}) begin
            s    = 4'(raw - BCD_TEN);
            cout = 1'b1;
        end else begin
            s    = raw[3:0];
            cout = 1'b0;
        end
    end
endmodule

// File: rtl/bcd_score_accum.sv
// N-digit BCD score accumulator: digit-serial add of a handshaked addend, LSD first,
// with leading-zero blanking, sticky overflow and optional saturation.
module bcd_score_accum
    import bcd_score_accum_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  add_valid,
    input  logic [4*DIGITS-1:0]   add_value,
    output logic                  add_ready,
    output logic [4*DIGITS-1:0]   data,
    output logic [DIGITS-1:0]     mask,
    output logic                  overflow,
    output logic                  done
);
    localparam int W  = 4 * DIGITS;
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [W-1:0]      ALL_NINES  = {DIGITS{BCD_NINE}};
    localparam logic [DIGITS-1:0] ZERO_MASK  = {{(DIGITS-1){1'b1}}, 1'b0};
    localparam logic [KW-1:0]     LAST_INDEX = KW'(DIGITS - 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t        state, state_next;
    logic [W-1:0]  work, addend, work_upd, commit_val;
    logic [KW-1:0] k;
    logic          carry, take, last_digit;
    logic [3:0]    work_digit, add_digit, sum_digit;
    logic          sum_cout;

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (r[4*i +: 4] > BCD_NINE) r[4*i +: 4] = BCD_NINE;
        return r;
    endfunction

    // Digit i is blanked only when it and every digit above it are zero.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [W-1:0] v);
        logic              zero_above;
        logic [DIGITS-1:0] m;
        m          = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (v[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    assign last_digit = (k == LAST_INDEX);

    always_comb begin
        work_digit = work[4*k +: 4];
        add_digit  = addend[4*k +: 4];
    end

    bcd_digit_add u_digit (
        .a    (work_digit),
        .b    (add_digit),
        .cin  (carry),
        .s    (sum_digit),
        .cout (sum_cout)
    );

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_next = state;
        add_ready  = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                add_ready = 1'b1;
                if (add_valid) begin
                    take       = 1'b1;
                    state_next = ADD;
                end
            end
            ADD:     if (last_digit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        work_upd            = work;
        work_upd[4*k +: 4]  = sum_digit;
        commit_val          = (sum_cout && SATURATE) ? ALL_NINES : work_upd;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) state <= IDLE;
        else              state <= state_next;
    end

    always_ff @(posedge clk) begin
        // NOTE: clear shares the reset branch, so an add in flight is dropped and never commits.
        if (rst || clear) begin
            work     <= '0;
            addend   <= '0;
            k        <= '0;
            carry    <= 1'b0;
            data     <= '0;
            mask     <= ZERO_MASK;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (take) begin
                addend <= clamp_bcd(add_value);
                work   <= data;
                k      <= '0;
                carry  <= 1'b0;
            end else if (state == ADD) begin
                work  <= work_upd;
                carry <= sum_cout;
                k     <= last_digit ? '0 : k + KW'(1);
                if (last_digit) begin
                    data <= commit_val;
                    mask <= blank_mask(commit_val);
                    done <= 1'b1;
                    if (sum_cout) overflow <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_score_accum.sv
// Self-checking bench: a saturating and a wrapping instance run the same addend stream.
module tb_bcd_score_accum;
    localparam int DIGITS = 6;
    localparam int W      = 4 * DIGITS;
    localparam int LAT    = DIGITS;

    logic              clk = 1'b0;
    logic              rst, clear, add_valid;
    logic [W-1:0]      add_value;
    logic              add_ready_s, overflow_s, done_s;
    logic [W-1:0]      data_s;
    logic [DIGITS-1:0] mask_s;
    logic              add_ready_w, overflow_w, done_w;
    logic [W-1:0]      data_w;
    logic [DIGITS-1:0] mask_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;

    typedef struct {
        logic [W-1:0]      addend;
        logic [W-1:0]      sat_data;
        logic [DIGITS-1:0] sat_mask;
        logic              sat_ovf;
        logic [W-1:0]      wrap_data;
        logic [DIGITS-1:0] wrap_mask;
        logic              wrap_ovf;
    } vec_t;

    typedef struct {
        vec_t v;
        int   due;
    } exp_t;

    exp_t sb[$];

    bcd_score_accum #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .add_valid(add_valid), .add_value(add_value),
        .add_ready(add_ready_s), .data(data_s), .mask(mask_s), .overflow(overflow_s), .done(done_s)
    );

    bcd_score_accum #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .clear(clear), .add_valid(add_valid), .add_value(add_value),
        .add_ready(add_ready_w), .data(data_w), .mask(mask_w), .overflow(overflow_w), .done(done_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done_s || done_w) begin
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done_s), 32'(0));
            end else begin
                e = sb.pop_front();
                check("done_pair",  32'(done_w),     32'(1));
                check("done_cycle", 32'(cyc),        32'(e.due));
                check("sat_data",   32'(data_s),     32'(e.v.sat_data));
                check("sat_mask",   32'(mask_s),     32'(e.v.sat_mask));
                check("sat_ovf",    32'(overflow_s), 32'(e.v.sat_ovf));
                check("wrap_data",  32'(data_w),     32'(e.v.wrap_data));
                check("wrap_mask",  32'(mask_w),     32'(e.v.wrap_mask));
                check("wrap_ovf",   32'(overflow_w), 32'(e.v.wrap_ovf));
                check("ready_back", 32'(add_ready_s), 32'(1));
            end
        end
    end

    task automatic send(input vec_t v);
        int guard;
        exp_t e;
        guard     = 0;
        add_valid = 1'b1;
        add_value = v.addend;
        while (!(add_ready_s && add_ready_w)) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                check("handshake_timeout", 32'(guard), 32'(0));
                add_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        add_valid = 1'b0;
        e.v   = v;
        e.due = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_data_s"},  32'(data_s),      32'(0));
        check({tag, "_mask_s"},  32'(mask_s),      32'(6'b111110));
        check({tag, "_ready_s"}, 32'(add_ready_s), 32'(1));
        check({tag, "_ovf_s"},   32'(overflow_s),  32'(0));
        check({tag, "_done_s"},  32'(done_s),      32'(0));
        check({tag, "_data_w"},  32'(data_w),      32'(0));
        check({tag, "_mask_w"},  32'(mask_w),      32'(6'b111110));
        check({tag, "_ovf_w"},   32'(overflow_w),  32'(0));
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_drained"}, 32'(sb.size()), 32'(0));
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        sb.delete();
    endtask

    initial begin
        vec_t vecs[8];
        vec_t v;
        int   h1, dc;

        vecs[0] = '{24'h000009, 24'h000009, 6'b111110, 1'b0, 24'h000009, 6'b111110, 1'b0};
        vecs[1] = '{24'h000001, 24'h000010, 6'b111100, 1'b0, 24'h000010, 6'b111100, 1'b0};
        vecs[2] = '{24'h999988, 24'h999998, 6'b000000, 1'b0, 24'h999998, 6'b000000, 1'b0};
        vecs[3] = '{24'h000005, 24'h999999, 6'b000000, 1'b1, 24'h000003, 6'b111110, 1'b1};
        vecs[4] = '{24'h000001, 24'h999999, 6'b000000, 1'b1, 24'h000004, 6'b111110, 1'b1};
        vecs[5] = '{24'h000000, 24'h999999, 6'b000000, 1'b1, 24'h000004, 6'b111110, 1'b1};
        vecs[6] = '{24'h00000C, 24'h999999, 6'b000000, 1'b1, 24'h000013, 6'b111100, 1'b1};
        vecs[7] = '{24'h123456, 24'h999999, 6'b000000, 1'b1, 24'h123469, 6'b000000, 1'b1};

        rst = 1'b1; clear = 1'b0; add_valid = 1'b0; add_value = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset");

        for (int i = 0; i < 8; i++) send(vecs[i]);
        drain("table");

        // clear drops sticky overflow and returns both instances to zero
        pulse_clear();
        check_idle_zero("clear");

        // add_valid held across a busy pass; addend changes while busy are ignored
        @(negedge clk);
        add_valid = 1'b1;
        add_value = 24'h000100;
        @(posedge clk);
        #1;
        h1 = cyc;
        v = '{24'h000100, 24'h000100, 6'b111000, 1'b0, 24'h000100, 6'b111000, 1'b0};
        sb.push_back('{v, h1 + LAT});
        add_value = 24'h777777;
        for (int i = 0; i < DIGITS; i++) begin
            @(negedge clk);
            check("busy_ready", 32'(add_ready_s), 32'(0));
            if (i == DIGITS - 2) add_value = 24'h000250;
        end
        @(negedge clk);
        check("ready_again", 32'(add_ready_s), 32'(1));
        @(posedge clk);
        #1;
        check("second_hs_cycle", 32'(cyc), 32'(h1 + LAT + 1));
        v = '{24'h000250, 24'h000350, 6'b111000, 1'b0, 24'h000350, 6'b111000, 1'b0};
        sb.push_back('{v, cyc + LAT});
        add_valid = 1'b0;
        drain("b2b");

        // clear in the middle of a pass: nothing commits
        pulse_clear();
        @(negedge clk);
        add_valid = 1'b1;
        add_value = 24'h123456;
        @(posedge clk);
        #1;
        add_valid = 1'b0;
        dc = done_count;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check_idle_zero("midclear");
        repeat (10) @(negedge clk);
        check("no_done_after_clear", 32'(done_count), 32'(dc));
        check("still_zero", 32'(data_s), 32'(0));

        v = '{24'h00000C, 24'h000009, 6'b111110, 1'b0, 24'h000009, 6'b111110, 1'b0};
        send(v);
        drain("clamp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
